amdemod_pipe: RTL and testbench

Fully pipelined, streaming AM envelope detector: computes sqrt(I² + Q²) or the power I² + Q² at one sample per clock, carries a valid flag, and selects the mode per sample. It sits after the I/Q decimation/CIC chain in the SDR receive path. It replaces the single-stage combinational-sqrt demodulator with a parametrised, timing-closed pipeline that tolerates gapped input streams.

---
 rtl/amdemod_pipe.sv | 118 +++++++++++
 tb/tb_amdemod_pipe.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/amdemod_pipe.sv
// amdemod_pipe: pipelined AM envelope (sqrt(I^2+Q^2)) / power detector, one sample per clock.
// Define AMDEMOD_DCBLOCK_EN to enable the leaky DC remover driving dc_out.
module amdemod_pipe #(
  parameter int DATA_WIDTH = 12,
  parameter int DC_SHIFT   = 8
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         in_valid,
  input  logic                         mode,
  input  logic signed [DATA_WIDTH-1:0] inphase,
  input  logic signed [DATA_WIDTH-1:0] quadrature,
  output logic                         out_valid,
  output logic        [DATA_WIDTH-1:0] amdemod_out,
  output logic                         out_mode,
  output logic signed [DATA_WIDTH:0]   dc_out
);
  localparam int W = DATA_WIDTH;
  localparam int N = 2 * W + 2;
  localparam int H = N / 2;
  localparam int R = W + 6;
  if (DC_SHIFT < 1 || DC_SHIFT > DATA_WIDTH) begin : g_bad_shift
    $error("DC_SHIFT out of range");
  end
  logic signed [2*W-1:0] sq_i, sq_q;
  logic                  v1, m1;
  logic [N-1:0]          sum;
  logic [N-1:0]          rad  [H];
  logic signed [R-1:0]   rem  [H];
  logic [W-1:0]          root [H];
  logic [W-1:0]          pwr  [H];
  logic                  vp   [H];
  logic                  mp   [H];
  logic signed [R-1:0]   rn   [1:H-1];
  logic [W-1:0]          qn   [1:H-1];
  logic                  last;
  logic [W-1:0]          mag;
  // One non-restoring iteration; the root never exceeds W bits since max < 2^W.
  function automatic logic signed [R-1:0] step(input logic signed [R-1:0] r,
                                               input logic [1:0] d,
                                               input logic [W-1:0] q);
    step = $signed({r[R-3:0], d}) +
           (r[R-1] ? $signed({4'b0, q, 2'b11}) : -$signed({4'b0, q, 2'b01}));
  endfunction
  assign sum = {2'b00, sq_i} + {2'b00, sq_q};
  always_comb begin
    for (int k = 1; k < H; k++) begin
      rn[k] = step(rem[k-1], rad[k-1][N-1 -: 2], root[k-1]);
      qn[k] = {root[k-1][W-2:0], ~rn[k][R-1]};
    end
  end
  assign last = step(rem[H-1], rad[H-1][N-1 -: 2], root[H-1]) >= 0;
  assign mag  = {root[H-1][W-2:0], last};
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v1 <= 1'b0;
      m1 <= 1'b0;
      sq_i <= '0;
      sq_q <= '0;
      for (int k = 0; k < H; k++) begin
        vp[k] <= 1'b0;
        mp[k] <= 1'b0;
        rad[k] <= '0;
        rem[k] <= '0;
        root[k] <= '0;
        pwr[k] <= '0;
      end
      out_valid <= 1'b0;
      out_mode <= 1'b0;
      amdemod_out <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        sq_i <= (2*W)'(inphase) * (2*W)'(inphase);
        sq_q <= (2*W)'(quadrature) * (2*W)'(quadrature);
        m1 <= mode;
      end
      vp[0] <= v1;
      if (v1) begin
        rad[0] <= sum;
        rem[0] <= '0;
        root[0] <= '0;
        pwr[0] <= sum[2*W-1 -: W];
        mp[0] <= m1;
      end
      for (int k = 1; k < H; k++) begin
        vp[k] <= vp[k-1];
        if (vp[k-1]) begin
          rad[k] <= rad[k-1] << 2;
          rem[k] <= rn[k];
          root[k] <= qn[k];
          pwr[k] <= pwr[k-1];
          mp[k] <= mp[k-1];
        end
      end
      out_valid <= vp[H-1];
      if (vp[H-1]) begin
        out_mode <= mp[H-1];
        amdemod_out <= mp[H-1] ? pwr[H-1] : mag;
      end
    end
  end
`ifdef AMDEMOD_DCBLOCK_EN
  logic signed [W:0] avg, dc_n;
  assign dc_n = $signed({1'b0, mag}) - avg;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      avg <= '0;
      dc_out <= '0;
    end else if (vp[H-1] && !mp[H-1]) begin
      dc_out <= dc_n;
      avg <= avg + (dc_n >>> DC_SHIFT);
    end
  end
`else
  assign dc_out = '0;
`endif
endmodule

// File: tb/tb_amdemod_pipe.sv
// tb_amdemod_pipe: directed vectors with hand-computed results, checked cycle by cycle.
module tb_amdemod_pipe;
  localparam int W = 12;
  localparam int L = 15;
  logic clk = 1'b0;
  logic arst, in_valid, mode;
  logic signed [W-1:0] inphase, quadrature;
  logic out_valid, out_mode;
  logic [W-1:0] amdemod_out;
  logic signed [W:0] dc_out;
  int checks = 0;
  int failures = 0;
  logic hv [L];
  logic hm [L];
  logic [W-1:0] hd [L];
  logic signed [W:0] hdc [L];
  logic [W-1:0] last_d;
  logic dc_on = 1'b0;

  amdemod_pipe #(.DATA_WIDTH(W), .DC_SHIFT(8)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .mode(mode),
    .inphase(inphase), .quadrature(quadrature), .out_valid(out_valid),
    .amdemod_out(amdemod_out), .out_mode(out_mode), .dc_out(dc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_hist;
    for (int k = 0; k < L; k++) begin
      hv[k] = 1'b0;
      hm[k] = 1'b0;
      hd[k] = '0;
      hdc[k] = '0;
    end
    last_d = '0;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    arst = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_amdemod_out", 32'(amdemod_out), 0);
    check("rst_out_mode", 32'(out_mode), 0);
    check("rst_dc_out", 32'(dc_out), 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    clear_hist();
  endtask

  task automatic cyc(input logic v, input logic m, input int i, input int q,
                     input int e, input int edc);
    in_valid = v;
    mode = m;
    inphase = W'(i);
    quadrature = W'(q);
    for (int k = L - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hm[k] = hm[k-1];
      hd[k] = hd[k-1];
      hdc[k] = hdc[k-1];
    end
    hv[0] = v;
    hm[0] = m;
    hd[0] = W'(e);
    hdc[0] = (W+1)'(edc);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(hv[L-1]));
    if (hv[L-1]) begin
      check("amdemod_out", 32'(amdemod_out), 32'(hd[L-1]));
      check("out_mode", 32'(out_mode), 32'(hm[L-1]));
      last_d = hd[L-1];
`ifdef AMDEMOD_DCBLOCK_EN
      if (dc_on) check("dc_out", 32'(dc_out), 32'(hdc[L-1]));
`endif
    end else begin
      check("hold_out", 32'(amdemod_out), 32'(last_d));
    end
`ifndef AMDEMOD_DCBLOCK_EN
    check("dc_zero", 32'(dc_out), 0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    in_valid = 1'b0;
    mode = 1'b0;
    inphase = '0;
    quadrature = '0;
    do_reset();
    // single sample, exact latency
    cyc(1, 0, 3, 4, 5, 0);
    idle(16);
    // extremes back to back
    cyc(1, 0, -2048, -2048, 2896, 0);
    cyc(1, 0, 2047, 0, 2047, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(15);
    // alternating modes, no bubbles
    cyc(1, 1, 2047, 0, 1023, 0);
    cyc(1, 0, 300, 400, 500, 0);
    cyc(1, 1, -2048, -2048, 2048, 0);
    cyc(1, 0, -1000, -1000, 1414, 0);
    cyc(1, 1, 1000, 0, 244, 0);
    cyc(1, 0, 5, 12, 13, 0);
    cyc(1, 1, 3, 4, 0, 0);
    idle(15);
    // gapped stream 1,0,0,1,1
    cyc(1, 0, 3, 4, 5, 0);
    idle(2);
    cyc(1, 0, 5, 12, 13, 0);
    cyc(1, 0, 300, 400, 500, 0);
    idle(15);
    // reset with 10 samples in flight
    repeat (10) cyc(1, 0, 7, 24, 25, 0);
    do_reset();
    idle(20);
    // DC remover: constant magnitude 1000, one power sample in between
    do_reset();
    dc_on = 1'b1;
    cyc(1, 0, 1000, 0, 1000, 1000);
    cyc(1, 0, 1000, 0, 1000, 997);
    cyc(1, 1, 1000, 0, 244, 997);
    cyc(1, 0, 1000, 0, 1000, 994);
    cyc(1, 0, 1000, 0, 1000, 991);
    idle(15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
